fixed_point_slow_scale: RTL and testbench

- Scales a 3-lane fixed-point vector by one scalar: P[i] = S * V[i].
- This is the inverse-direction companion of the dot-product unit. It turns a scalar, such as a projection or lighting coefficient, back into a vector for the geometry/shading pipeline.
- One shared multiplier is time-multiplexed over the three lanes, so the block is area-cheap and multi-cycle.
- Uses a valid/ready handshake on both input and output.

---
 rtl/fixed_point_slow_scale.sv | 152 +++++++++++++++
 tb/tb_fixed_point_slow_scale.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_slow_scale.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_slow_scale
//  Purpose  : P[i] = S * V[i] over three lanes through one shared multiplier,
//             with valid/ready handshakes on input and output.
//  Option   : FIXED_POINT_SLOW_SCALE_SAT_EN enables saturation and overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_point_slow_scale #(
    parameter int S_WIDTH     = 16,
    parameter int S_FRAC_BITS = 14,
    parameter int V_WIDTH     = 16,
    parameter int V_FRAC_BITS = 14,
    parameter int P_WIDTH     = 16,
    parameter int P_FRAC_BITS = 14
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [S_WIDTH-1:0]     s_in,
    input  logic [3*V_WIDTH-1:0]   v_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*P_WIDTH-1:0]   p_out,
    output logic                   overflow
);

    localparam int c_prod_w = S_WIDTH + V_WIDTH;
    localparam int c_sh     = S_FRAC_BITS + V_FRAC_BITS - P_FRAC_BITS;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  r_idx;
    logic signed [S_WIDTH-1:0]   r_s;
    logic [3*V_WIDTH-1:0]        r_v;
    logic [3*P_WIDTH-1:0]        r_p;

    logic signed [V_WIDTH-1:0]   w_v_lane;
    logic signed [c_prod_w-1:0]  w_prod;
    logic [P_WIDTH-1:0]          w_lane;
    logic                        w_accept;
    logic                        w_busy;

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign p_out     = r_p;
    assign w_accept  = in_valid && (r_state == c_idle);
    assign w_busy    = (r_state == c_busy);

    always_comb begin
        w_v_lane = r_v[V_WIDTH-1:0];
        case (r_idx)
            2'd1:    w_v_lane = r_v[V_WIDTH +: V_WIDTH];
            2'd2:    w_v_lane = r_v[2*V_WIDTH +: V_WIDTH];
            default: w_v_lane = r_v[V_WIDTH-1:0];
        endcase
    end

    // Both operands are signed, so the product is sign-extended to full width.
    assign w_prod = r_s * w_v_lane;

`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
    localparam logic signed [c_prod_w-1:0] c_p_max =
        {{(c_prod_w-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [c_prod_w-1:0] c_p_min =
        {{(c_prod_w-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

    logic signed [c_prod_w-1:0]  w_shift;
    logic                        w_lane_ovf;
    logic                        r_overflow;

    assign w_shift = w_prod >>> c_sh;

    always_comb begin
        w_lane     = w_shift[P_WIDTH-1:0];
        w_lane_ovf = 1'b0;
        if (w_shift > c_p_max) begin
            w_lane     = c_p_max[P_WIDTH-1:0];
            w_lane_ovf = 1'b1;
        end else if (w_shift < c_p_min) begin
            w_lane     = c_p_min[P_WIDTH-1:0];
            w_lane_ovf = 1'b1;
        end
    end

    // Sticky across the three lanes of one operation, cleared by the next accept.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_overflow <= 1'b0;
        end else if (w_busy && w_lane_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    // Flooring shift, then wrap by dropping the upper bits.
    assign w_lane   = P_WIDTH'(w_prod >>> c_sh);
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_idle;
            r_idx   <= 2'd0;
            r_s     <= '0;
            r_v     <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_s     <= s_in;
                        r_v     <= v_in;
                        r_idx   <= 2'd0;
                        r_state <= c_busy;
                    end
                end
                c_busy: begin
                    case (r_idx)
                        2'd0:    r_p[0 +: P_WIDTH]         <= w_lane;
                        2'd1:    r_p[P_WIDTH +: P_WIDTH]   <= w_lane;
                        default: r_p[2*P_WIDTH +: P_WIDTH] <= w_lane;
                    endcase
                    if (r_idx == 2'd2) begin
                        r_idx   <= 2'd0;
                        r_state <= c_done;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_idx   <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_slow_scale.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_point_slow_scale
//  Purpose  : Self-checking bench for fixed_point_slow_scale against a
//             floor-division reference model (FIXED_POINT_SLOW_SCALE_SAT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_slow_scale;

    localparam int SH = 14;

    logic        clk_in;
    logic        rst_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] s_in;
    logic [47:0] v_in;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] p_out;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    fixed_point_slow_scale dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .v_in      (v_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out),
        .overflow  (overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: floor(S*V / 2^SH), then wrap or clamp into 16 signed bits.
    function automatic logic [15:0] ref_lane(input int s, input int v, output bit ovf);
        longint prod, d, q;
        prod = longint'(s) * longint'(v);
        d    = longint'(1) << SH;
        q    = prod / d;
        if ((prod % d) != 0 && prod < 0) q = q - 1;
        ovf = 1'b0;
`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
        if (q > 32767) begin
            q = 32767;
            ovf = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            ovf = 1'b1;
        end
`endif
        return 16'(q);
    endfunction

    function automatic logic [47:0] ref_vec(input logic [15:0] s, input logic [47:0] v,
                                            output bit ovf);
        logic [47:0] r;
        bit o;
        ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r[16*i +: 16] = ref_lane(int'($signed(s)), int'($signed(v[16*i +: 16])), o);
            ovf = ovf | o;
        end
        return r;
    endfunction

    // Drives one operand, returns edges from accept to out_valid (bounded).
    task automatic send_op(input logic [15:0] s, input logic [47:0] v, output int lat);
        @(negedge clk_in);
        s_in = s;
        v_in = v;
        in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk_in);
        out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s_in = '0;
        v_in = '0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (p_out !== 48'h0) begin n_err++; $display("FAIL reset_p_out got=%h exp=0", p_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [47:0] v;
        v = {16'sd4096, -16'sd16384, 16'sd16384};
        e = ref_vec(16'sd8192, v, eo);
        send_op(16'sd8192, v, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        n_cmp++; if (p_out !== {16'sd2048, -16'sd8192, 16'sd8192}) begin n_err++; $display("FAIL basic_const got=%h exp=%h", p_out, {16'sd2048, -16'sd8192, 16'sd8192}); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL basic_model got=%h exp=%h", p_out, e); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
        drain();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL basic_retain got=%h exp=%h", p_out, e); end
    endtask

    task automatic test_overflow();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [15:0] lane0;
        e = ref_vec(16'sd24576, {16'sd0, 16'sd0, 16'sd24576}, eo);
`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
        lane0 = 16'sd32767;
`else
        lane0 = -16'sd28672;
`endif
        send_op(16'sd24576, {16'sd0, 16'sd0, 16'sd24576}, lat);
        n_cmp++; if (p_out[15:0] !== lane0) begin n_err++; $display("FAIL ovf_lane0 got=%h exp=%h", p_out[15:0], lane0); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL ovf_model got=%h exp=%h", p_out, e); end
        n_cmp++; if (overflow !== eo) begin n_err++; $display("FAIL ovf_flag got=%b exp=%b", overflow, eo); end
        drain();
    endtask

    task automatic test_negative();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [47:0] v;
        logic [15:0] lane0;
        v = {16'sd1, 16'sd32767, -16'sd32768};
        e = ref_vec(-16'sd32768, v, eo);
`ifdef FIXED_POINT_SLOW_SCALE_SAT_EN
        lane0 = 16'sd32767;
`else
        lane0 = 16'sd0;
`endif
        send_op(-16'sd32768, v, lat);
        n_cmp++; if (p_out[15:0] !== lane0) begin n_err++; $display("FAIL neg_lane0 got=%h exp=%h", p_out[15:0], lane0); end
        n_cmp++; if (p_out[47:32] !== 16'hfffe) begin n_err++; $display("FAIL neg_lane2 got=%h exp=fffe", p_out[47:32]); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL neg_model got=%h exp=%h", p_out, e); end
        n_cmp++; if (overflow !== eo) begin n_err++; $display("FAIL neg_flag got=%b exp=%b", overflow, eo); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [15:0] s;
        logic [47:0] v;
        s = 16'($urandom);
        v = {16'($urandom), 16'($urandom), 16'($urandom)};
        e = ref_vec(s, v, eo);
        send_op(s, v, lat);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            in_valid = i[0];
            s_in = 16'($urandom);
            v_in = {16'($urandom), 16'($urandom), 16'($urandom)};
            out_ready = 1'b0;
            @(posedge clk_in);
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
            n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, p_out, e); end
        end
        @(negedge clk_in);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL bp_retain got=%h exp=%h", p_out, e); end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [15:0] s;
        logic [47:0] v;
        @(negedge clk_in);
        s_in = 16'sd16384;
        v_in = {16'sd300, 16'sd200, 16'sd100};
        in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_valid got=%b exp=0", out_valid); end
        n_cmp++; if (p_out !== 48'h0) begin n_err++; $display("FAIL rst_busy_p_out got=%h exp=0", p_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_busy_ready got=%b exp=1", in_ready); end
        @(negedge clk_in);
        rst_in = 1'b1;
        s = 16'($urandom);
        v = {16'($urandom), 16'($urandom), 16'($urandom)};
        e = ref_vec(s, v, eo);
        send_op(s, v, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rst_after_latency got=%0d exp=3", lat); end
        n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL rst_after_model got=%h exp=%h", p_out, e); end
        n_cmp++; if (overflow !== eo) begin n_err++; $display("FAIL rst_after_flag got=%b exp=%b", overflow, eo); end
        drain();
    endtask

    task automatic test_random();
        int lat;
        bit eo;
        logic [47:0] e;
        logic [15:0] s;
        logic [47:0] v;
        for (int n = 0; n < 8; n++) begin
            s = 16'($urandom);
            v = {16'($urandom), 16'($urandom), 16'($urandom)};
            e = ref_vec(s, v, eo);
            send_op(s, v, lat);
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rand_latency[%0d] got=%0d exp=3", n, lat); end
            n_cmp++; if (p_out !== e) begin n_err++; $display("FAIL rand_model[%0d] s=%h v=%h got=%h exp=%h", n, s, v, p_out, e); end
            n_cmp++; if (overflow !== eo) begin n_err++; $display("FAIL rand_flag[%0d] got=%b exp=%b", n, overflow, eo); end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bs[4];
        logic [47:0] bv[4];
        logic [47:0] be[4];
        bit          bo[4];
        int          acc[4];
        int          k;
        int          r;
        for (int i = 0; i < 4; i++) begin
            bs[i] = 16'($urandom);
            bv[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
            be[i] = ref_vec(bs[i], bv[i], bo[i]);
            acc[i] = -1;
        end
        k = 0;
        r = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
            @(negedge clk_in);
            if (out_valid) begin
                n_cmp++; if (p_out !== be[r]) begin n_err++; $display("FAIL b2b_model[%0d] got=%h exp=%h", r, p_out, be[r]); end
                n_cmp++; if (overflow !== bo[r]) begin n_err++; $display("FAIL b2b_flag[%0d] got=%b exp=%b", r, overflow, bo[r]); end
                r++;
            end
            if (in_ready && k < 4) begin
                s_in = bs[k];
                v_in = bv[k];
                in_valid = 1'b1;
                acc[k] = cyc;
                k++;
            end else begin
                s_in = 16'($urandom);
                v_in = {16'($urandom), 16'($urandom), 16'($urandom)};
                in_valid = (k < 4);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (r !== 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", r); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (acc[i] - acc[i-1] !== 5) begin n_err++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", i, acc[i] - acc[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_negative();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
